// File: rtl/sdram_req_arbiter.sv
// Command arbiter and burst sequencer in front of the 16-bit SDRAM controller.
// Arbitrates video refill, cache write-back and cache fill, then steers each burst's data beats.
module sdram_req_arbiter #(
  parameter logic [14:0] VID_BASE_BLK = 15'h6FF8,
  parameter int unsigned VID_BLOCKS   = 3072,
  parameter int unsigned VID_BEATS    = 16,
  parameter int unsigned LINE_BEATS   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vq_almost_empty,
  input  logic        cache_wr_req,
  input  logic        cache_rd_req,
  input  logic [11:0] cache_waddr,
  input  logic [11:0] cache_raddr,
  input  logic        frame_sync,
  output logic [1:0]  sys_cmd,
  output logic [17:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_fill_stb,
  output logic        cache_drain_stb,
  output logic [31:0] vq_wdata,
  output logic        vq_wr,
  output logic        busy,
  output logic [11:0] vid_blk
);
  localparam int unsigned BLK_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_VRD = 2'b10;
  localparam logic [1:0] CMD_LRD = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cmd_kind;
  logic [1:0]       ack_q;
  logic [CNT_W-1:0] beat_cnt;
  logic             pack_tgl;
  logic [15:0]      low_half;
  logic             frame_pend;

  logic [14:0]      vid_blk_addr_c;
  logic [1:0]       req_cmd_c;
  logic [17:0]      req_addr_c;
  logic             ack_take_c;
  logic             beat_c;
  logic             last_beat_c;
  logic             vid_done_c;
  logic             vid_active_c;
  logic             vid_launch_c;

  // Framebuffer blocks are laid out with the upper index bits inverted
  assign vid_blk_addr_c = VID_BASE_BLK + {3'b000, ~vid_blk[11:2], vid_blk[1:0]};

  // Fixed priority: video > write-back > fill
  always_comb begin
    req_cmd_c  = CMD_NOP;
    req_addr_c = '0;
    if (vq_almost_empty) begin
      req_cmd_c  = CMD_VRD;
      req_addr_c = {vid_blk_addr_c, 3'b000};
    end else if (cache_wr_req) begin
      req_cmd_c  = CMD_WR;
      req_addr_c = {cache_waddr, 6'b000000};
    end else if (cache_rd_req) begin
      req_cmd_c  = CMD_LRD;
      req_addr_c = {cache_raddr, 6'b000000};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_cmd_c != CMD_NOP) state_nxt = REQ;
      REQ:     if (ack_take_c)           state_nxt = XFER;
      XFER:    if (last_beat_c)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ack accepted only on a 00 -> matching-code transition
  always_comb begin
    ack_take_c      = (state == REQ) && (ack_q == CMD_NOP) && (sys_cmd_ack == cmd_kind);
    beat_c          = (state == XFER) &&
                      ((cmd_kind == CMD_WR) ? sys_wr_data_valid : sys_rd_data_valid);
    last_beat_c     = beat_c && (beat_cnt == ((cmd_kind == CMD_VRD) ? CNT_W'(VID_BEATS - 1)
                                                                      : CNT_W'(LINE_BEATS - 1)));
    vid_done_c      = last_beat_c && (cmd_kind == CMD_VRD);
    vid_active_c    = (state != IDLE) && (cmd_kind == CMD_VRD);
    vid_launch_c    = (state == IDLE) && (req_cmd_c == CMD_VRD);
    cache_fill_stb  = (state == XFER) && (cmd_kind == CMD_LRD) && sys_rd_data_valid;
    cache_drain_stb = (state == XFER) && (cmd_kind == CMD_WR) && sys_wr_data_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_cmd    <= CMD_NOP;
      sys_addr   <= '0;
      cmd_kind   <= CMD_NOP;
      ack_q      <= CMD_NOP;
      beat_cnt   <= '0;
      pack_tgl   <= 1'b0;
      low_half   <= '0;
      vq_wdata   <= '0;
      vq_wr      <= 1'b0;
      busy       <= 1'b0;
      vid_blk    <= '0;
      frame_pend <= 1'b0;
    end else begin
      ack_q <= sys_cmd_ack;
      vq_wr <= 1'b0;
      busy  <= (state_nxt != IDLE);
      case (state)
        IDLE: if (req_cmd_c != CMD_NOP) begin
          sys_cmd  <= req_cmd_c;
          sys_addr <= req_addr_c;
          cmd_kind <= req_cmd_c;
        end
        REQ: if (ack_take_c) begin
          sys_cmd  <= CMD_NOP;
          beat_cnt <= '0;
          pack_tgl <= 1'b0;
        end
        XFER: if (beat_c) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (cmd_kind == CMD_VRD) begin
            pack_tgl <= ~pack_tgl;
            if (!pack_tgl) begin
              low_half <= sys_dout;
            end else begin
              vq_wdata <= {sys_dout, low_half};
              vq_wr    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Frame restart during a video burst is deferred to its completion
      if (vid_done_c) begin
        frame_pend <= 1'b0;
        if (frame_pend || frame_sync || (vid_blk == BLK_W'(VID_BLOCKS - 1))) vid_blk <= '0;
        else                                                                 vid_blk <= vid_blk + 1'b1;
      end else if (frame_sync) begin
        if (vid_active_c || vid_launch_c) frame_pend <= 1'b1;
        if (!vid_active_c)                vid_blk    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: vector table of request mixes plus hand-written corner sequences.
// Packed video words are checked against a queue filled as beats are driven.
module tb_sdram_req_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vq_almost_empty = 1'b0;
  logic        cache_wr_req = 1'b0;
  logic        cache_rd_req = 1'b0;
  logic [11:0] cache_waddr = '0;
  logic [11:0] cache_raddr = '0;
  logic        frame_sync = 1'b0;
  logic [1:0]  sys_cmd;
  logic [17:0] sys_addr;
  logic [1:0]  sys_cmd_ack = '0;
  logic        sys_rd_data_valid = 1'b0;
  logic        sys_wr_data_valid = 1'b0;
  logic [15:0] sys_dout = '0;
  logic        cache_fill_stb;
  logic        cache_drain_stb;
  logic [31:0] vq_wdata;
  logic        vq_wr;
  logic        busy;
  logic [11:0] vid_blk;

  sdram_req_arbiter dut (
    .clk(clk), .rst(rst),
    .vq_almost_empty(vq_almost_empty), .cache_wr_req(cache_wr_req), .cache_rd_req(cache_rd_req),
    .cache_waddr(cache_waddr), .cache_raddr(cache_raddr), .frame_sync(frame_sync),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout(sys_dout), .cache_fill_stb(cache_fill_stb), .cache_drain_stb(cache_drain_stb),
    .vq_wdata(vq_wdata), .vq_wr(vq_wr), .busy(busy), .vid_blk(vid_blk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vq, wr, rd;
    logic [11:0] waddr, raddr;
    logic [1:0]  exp_cmd;
    logic [17:0] exp_addr;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_vq = 0, n_fill = 0, n_drain = 0;
  int          m_blk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and strobe counters sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (vq_wr) begin
        n_vq++;
        if (exp_q.size() == 0) check("vq_wr_unexpected", 32'd1, 32'd0);
        else begin
          exp_w = exp_q.pop_front();
          check("vq_wdata", vq_wdata, exp_w);
        end
      end
      if (cache_fill_stb)  n_fill++;
      if (cache_drain_stb) n_drain++;
    end
  end

  task automatic drive_req(input logic vq, input logic wr, input logic rd,
                           input logic [11:0] wa, input logic [11:0] ra);
    vq_almost_empty = vq; cache_wr_req = wr; cache_rd_req = rd;
    cache_waddr = wa; cache_raddr = ra;
  endtask

  task automatic do_ack(input logic [1:0] code);
    sys_cmd_ack = code;
    tick();
    sys_cmd_ack = 2'b00;
  endtask

  task automatic video_beats(input logic [15:0] first, input bit rnd, input int nb, input int fs_beat);
    logic [15:0] d, lo;
    lo = '0;
    for (int b = 0; b < nb; b++) begin
      d = rnd ? 16'($urandom) : first + 16'(b);
      sys_rd_data_valid = 1'b1;
      sys_dout = d;
      frame_sync = (b == fs_beat);
      if (b % 2 == 1) exp_q.push_back({d, lo});
      else            lo = d;
      tick();
    end
    sys_rd_data_valid = 1'b0;
    frame_sync = 1'b0;
    if (nb == 16) begin
      if (fs_beat >= 0 || m_blk == 3071) m_blk = 0;
      else                              m_blk = m_blk + 1;
    end
  endtask

  task automatic line_beats(input bit wr);
    for (int b = 0; b < 128; b++) begin
      if (wr) sys_wr_data_valid = 1'b1;
      else    sys_rd_data_valid = 1'b1;
      sys_dout = 16'($urandom);
      tick();
    end
    sys_wr_data_valid = 1'b0;
    sys_rd_data_valid = 1'b0;
  endtask

  task automatic vid_burst_fast(input int fs_beat);
    drive_req(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    tick();
    drive_req(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    do_ack(2'b10);
    video_beats(16'h0, 1'b1, 16, fs_beat);
  endtask

  task automatic clear_counts();
    n_vq = 0; n_fill = 0; n_drain = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 12'h000, 12'h000, 2'b10, 18'h3FFA0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 12'hABC, 12'h123, 2'b01, 18'h2AF00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 12'hABC, 12'h123, 2'b11, 18'h048C0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 12'h555, 12'h000, 2'b10, 18'h3FFA8};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'hFFF, 2'b11, 18'h3FFC0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 12'h000, 12'h001, 2'b10, 18'h3FFB0};

    // Reset with every request asserted
    drive_req(1'b1, 1'b1, 1'b1, 12'h000, 12'h000);
    repeat (3) tick();
    check("rst_sys_cmd", 32'(sys_cmd), 32'd0);
    check("rst_sys_addr", 32'(sys_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vid_blk", 32'(vid_blk), 32'd0);
    check("rst_strobes", {29'd0, vq_wr, cache_fill_stb, cache_drain_stb}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive_req(vecs[i].vq, vecs[i].wr, vecs[i].rd, vecs[i].waddr, vecs[i].raddr);
      tick();
      check($sformatf("vec%0d_cmd", i), 32'(sys_cmd), 32'(vecs[i].exp_cmd));
      check($sformatf("vec%0d_addr", i), 32'(sys_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      drive_req(1'b0, 1'b0, 1'b0, vecs[i].waddr, vecs[i].raddr);
      clear_counts();
      do_ack(vecs[i].exp_cmd);
      check($sformatf("vec%0d_cmd_cleared", i), 32'(sys_cmd), 32'd0);
      if (vecs[i].exp_cmd == 2'b10) video_beats(16'h0001 + 16'(i * 16), 1'b0, 16, -1);
      else                          line_beats(vecs[i].exp_cmd == 2'b01);
      tick();
      check($sformatf("vec%0d_vq_wr_count", i), 32'(n_vq), (vecs[i].exp_cmd == 2'b10) ? 32'd8 : 32'd0);
      check($sformatf("vec%0d_drain_count", i), 32'(n_drain), (vecs[i].exp_cmd == 2'b01) ? 32'd128 : 32'd0);
      check($sformatf("vec%0d_fill_count", i), 32'(n_fill), (vecs[i].exp_cmd == 2'b11) ? 32'd128 : 32'd0);
      check($sformatf("vec%0d_busy_done", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_vid_blk", i), 32'(vid_blk), 32'(m_blk));
    end

    // Stray beats in IDLE and REQ, wrong ack code in REQ
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      sys_rd_data_valid = 1'b1; sys_wr_data_valid = 1'b1;
      tick();
    end
    sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
    drive_req(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    tick();
    drive_req(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    sys_rd_data_valid = 1'b1;
    do_ack(2'b01);
    sys_rd_data_valid = 1'b0;
    check("bad_ack_cmd_held", 32'(sys_cmd), 32'd2);
    check("bad_ack_busy", 32'(busy), 32'd1);
    tick();
    check("stray_no_strobes", 32'(n_vq + n_fill + n_drain), 32'd0);
    do_ack(2'b10);
    check("good_ack_cmd_cleared", 32'(sys_cmd), 32'd0);
    video_beats(16'h0, 1'b1, 16, -1);
    tick();
    check("after_bad_ack_vq_count", 32'(n_vq), 32'd8);

    // frame_sync outside a burst, then mid-burst at block 5
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    m_blk = 0;
    check("fs_idle_vid_blk", 32'(vid_blk), 32'd0);
    repeat (5) vid_burst_fast(-1);
    tick();
    check("fs_pre_vid_blk", 32'(vid_blk), 32'd5);
    vid_burst_fast(4);
    tick();
    check("fs_mid_burst_vid_blk", 32'(vid_blk), 32'd0);

    // Reset during beat 7 of a video burst
    vid_burst_fast(-1);
    drive_req(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    tick();
    drive_req(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    do_ack(2'b10);
    video_beats(16'h0100, 1'b0, 7, -1);
    sys_rd_data_valid = 1'b1;
    sys_dout = 16'h0107;
    #2;
    rst = 1'b0;
    #1;
    check("arst_sys_cmd", 32'(sys_cmd), 32'd0);
    check("arst_sys_addr", 32'(sys_addr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_vq_wdata", vq_wdata, 32'd0);
    check("arst_vid_blk", 32'(vid_blk), 32'd0);
    check("arst_strobes", {29'd0, vq_wr, cache_fill_stb, cache_drain_stb}, 32'd0);
    check("arst_words_before", 32'(exp_q.size()), 32'd0);
    sys_rd_data_valid = 1'b0;
    m_blk = 0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    drive_req(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    tick();
    check("post_rst_cmd", 32'(sys_cmd), 32'd2);
    check("post_rst_addr", 32'(sys_addr), 32'h3FFA0);
    drive_req(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    clear_counts();
    do_ack(2'b10);
    video_beats(16'h0200, 1'b0, 16, -1);
    tick();
    check("post_rst_vq_count", 32'(n_vq), 32'd8);

    // Walk to the last block of the frame and wrap
    while (m_blk != 3071) vid_burst_fast(-1);
    tick();
    check("pre_wrap_vid_blk", 32'(vid_blk), 32'd3071);
    drive_req(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    tick();
    check("last_blk_addr", 32'(sys_addr), 32'h39FD8);
    drive_req(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    do_ack(2'b10);
    video_beats(16'h0, 1'b1, 16, -1);
    tick();
    check("wrap_vid_blk", 32'(vid_blk), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
